// File: rtl/rc4_stream.sv
// RC4 keystream generator: run-time key length, drop[n] support, valid/ready byte output.
// The S-box lives in flops so each KSA or PRGA step retires in a single cycle.
module rc4_stream #(
   parameter int KEY_MAX = 16,
   parameter int LEN_W   = 5,
   parameter int DROP_W  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [8*KEY_MAX-1:0]   key,
   input  logic [LEN_W-1:0]       key_len,
   input  logic [DROP_W-1:0]      drop_n,
   output logic [7:0]             ks_data,
   output logic                   ks_valid,
   input  logic                   ks_ready,
   output logic                   busy,
   output logic                   key_err
);
   typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, GEN} state_t;

   localparam logic [LEN_W-1:0] KEY_MAX_L = LEN_W'(KEY_MAX);

   state_t                 state_q, state_d;
   logic [7:0]             s_q [256];
   logic [7:0]             s_d [256];
   logic [7:0]             i_q, i_d, j_q, j_d;
   logic [LEN_W-1:0]       kidx_q, kidx_d, klen_q, klen_d;
   logic [8*KEY_MAX-1:0]   key_q, key_d;
   logic [DROP_W-1:0]      drop_q, drop_d;
   logic [7:0]             ks_data_q, ks_data_d;
   logic                   ks_valid_q, ks_valid_d;
   logic                   key_err_q, key_err_d;

   logic                   len_ok, start_ok, gen_step;
   logic [7:0]             kbyte, ksi, kj, ksj;
   logic [7:0]             pi, psi, pj, psj, pt, pout;

   assign len_ok   = (key_len != '0) && (key_len <= KEY_MAX_L);
   assign start_ok = (state_q == IDLE) && start && len_ok;
   assign gen_step = !ks_valid_q || ks_ready;

   always_comb begin
      kbyte = '0;
      for (int k = 0; k < KEY_MAX; k++)
         if (kidx_q == LEN_W'(k)) kbyte = key_q[8*k +: 8];
   end

   // KSA and PRGA operands; the PRGA output read is forwarded around the swap
   assign ksi  = s_q[i_q];
   assign kj   = j_q + ksi + kbyte;
   assign ksj  = s_q[kj];
   assign pi   = i_q + 8'd1;
   assign psi  = s_q[pi];
   assign pj   = j_q + psi;
   assign psj  = s_q[pj];
   assign pt   = psi + psj;
   assign pout = (pt == pi) ? psj : (pt == pj) ? psi : s_q[pt];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_ok) state_d = INIT;
         INIT: state_d = KSA;
         KSA:  if (i_q == 8'hFF) state_d = (drop_q != '0) ? DROP : GEN;
         DROP: if (drop_q == DROP_W'(1)) state_d = GEN;
         GEN:  state_d = GEN;
         default: state_d = IDLE;
      endcase
      if (stop && state_q != IDLE) state_d = IDLE;
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_comb begin
      s_d        = s_q;
      i_d        = i_q;
      j_d        = j_q;
      kidx_d     = kidx_q;
      klen_d     = klen_q;
      key_d      = key_q;
      drop_d     = drop_q;
      ks_data_d  = ks_data_q;
      ks_valid_d = ks_valid_q;
      key_err_d  = (state_q == IDLE) && start && !len_ok;
      case (state_q)
         IDLE: if (start_ok) begin
            key_d  = key;
            klen_d = key_len;
            drop_d = drop_n;
         end
         INIT: begin
            for (int x = 0; x < 256; x++) s_d[x] = 8'(x);
            i_d    = '0;
            j_d    = '0;
            kidx_d = '0;
         end
         KSA: begin
            s_d[i_q] = ksj;
            s_d[kj]  = ksi;
            i_d      = i_q + 8'd1;
            j_d      = (i_q == 8'hFF) ? 8'd0 : kj;
            kidx_d   = (kidx_q == klen_q - 1'b1) ? '0 : kidx_q + 1'b1;
         end
         DROP: begin
            s_d[pi] = psj;
            s_d[pj] = psi;
            i_d     = pi;
            j_d     = pj;
            drop_d  = drop_q - 1'b1;
         end
         GEN: if (gen_step) begin
            s_d[pi]    = psj;
            s_d[pj]    = psi;
            i_d        = pi;
            j_d        = pj;
            ks_data_d  = pout;
            ks_valid_d = 1'b1;
         end
         default: ;
      endcase
      if (stop && state_q != IDLE) ks_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int x = 0; x < 256; x++) s_q[x] <= 8'(x);
         i_q        <= '0;
         j_q        <= '0;
         kidx_q     <= '0;
         klen_q     <= '0;
         key_q      <= '0;
         drop_q     <= '0;
         ks_data_q  <= '0;
         ks_valid_q <= 1'b0;
         key_err_q  <= 1'b0;
      end else begin
         s_q        <= s_d;
         i_q        <= i_d;
         j_q        <= j_d;
         kidx_q     <= kidx_d;
         klen_q     <= klen_d;
         key_q      <= key_d;
         drop_q     <= drop_d;
         ks_data_q  <= ks_data_d;
         ks_valid_q <= ks_valid_d;
         key_err_q  <= key_err_d;
      end
   end

   assign ks_data  = ks_data_q;
   assign ks_valid = ks_valid_q;
   assign key_err  = key_err_q;
endmodule

// File: tb/tb_rc4_stream.sv
// Scoreboard bench for rc4_stream: known RC4 vectors, drop[n], backpressure, errors, stop/reset.
module tb_rc4_stream;
   localparam int KEY_MAX = 16;
   localparam int LEN_W   = 5;
   localparam int DROP_W  = 10;

   logic                 clk = 1'b0;
   logic                 rst, start, stop, ks_ready;
   logic [8*KEY_MAX-1:0] key;
   logic [LEN_W-1:0]     key_len;
   logic [DROP_W-1:0]    drop_n;
   logic [7:0]           ks_data;
   logic                 ks_valid, busy, key_err;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] sb_q[$];

   rc4_stream #(.KEY_MAX(KEY_MAX), .LEN_W(LEN_W), .DROP_W(DROP_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key), .key_len(key_len),
      .drop_n(drop_n), .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .busy(busy), .key_err(key_err)
   );

   always #5 clk = ~clk;

   function automatic logic [8*KEY_MAX-1:0] mk_key(input string s);
      logic [8*KEY_MAX-1:0] k;
      k = '0;
      for (int n = 0; n < s.len(); n++) k[8*n +: 8] = s[n];
      return k;
   endfunction

   // Leaves the bench at the negedge right after the accepting edge E0, inputs scrambled
   task automatic do_start(input string s, input int len, input int drop);
      @(negedge clk);
      key = mk_key(s); key_len = LEN_W'(len); drop_n = DROP_W'(drop); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; key = {KEY_MAX{8'hA5}}; key_len = LEN_W'(1); drop_n = DROP_W'(7);
   endtask

   task automatic wait_first(input int exp_lat, input string name);
      int n = 0;
      while (!ks_valid && n < 2000) begin
         @(posedge clk); n++; @(negedge clk);
      end
      tests++;
      if (n !== exp_lat) begin
         fails++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
      end
   endtask

   task automatic drain(input bit rnd, input string name);
      int         cyc = 0;
      int         want_cyc;
      bit         stalled = 0;
      logic [7:0] prev = '0;
      logic [7:0] exp_b;
      want_cyc = sb_q.size();
      while (sb_q.size() > 0 && cyc < 4000) begin
         if (stalled) begin
            tests++;
            if (ks_data !== prev || ks_valid !== 1'b1) begin
               fails++; $display("FAIL %s stall hold: got %h/%b want %h/1", name, ks_data, ks_valid, prev);
            end
         end
         ks_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         if (ks_valid && ks_ready) begin
            exp_b = sb_q.pop_front();
            tests++;
            if (ks_data !== exp_b) begin
               fails++; $display("FAIL %s byte: got %h want %h", name, ks_data, exp_b);
            end
            stalled = 0;
         end else begin
            stalled = ks_valid;
            prev    = ks_data;
         end
         @(posedge clk); @(negedge clk); cyc++;
      end
      if (sb_q.size() != 0) begin
         tests++; fails++;
         $display("FAIL %s timeout: got %0d left want 0", name, sb_q.size());
      end else if (!rnd) begin
         tests++;
         if (cyc !== want_cyc) begin
            fails++; $display("FAIL %s throughput: got %0d cycles want %0d", name, cyc, want_cyc);
         end
      end
      sb_q.delete();
      ks_ready = 1'b1;
   endtask

   task automatic stop_run();
      @(negedge clk); stop = 1'b1;
      @(posedge clk);
      @(negedge clk); stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b1;
      key = '0; key_len = '0; drop_n = '0;
      repeat (2) @(negedge clk);
      tests++;
      if (ks_valid !== 1'b0 || busy !== 1'b0 || key_err !== 1'b0 || ks_data !== 8'h00) begin
         fails++; $display("FAIL reset: got v%b b%b e%b d%h want 0 0 0 00", ks_valid, busy, key_err, ks_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      do_start("Key", 3, 0);
      wait_first(258, "key");
      sb_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
      drain(0, "key");
      stop_run();
      do_start("Secret", 6, 0);
      wait_first(258, "secret");
      sb_q = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
      drain(0, "secret");
      stop_run();
      do_start("Wiki", 4, 0);
      wait_first(258, "wiki");
      sb_q = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
      drain(0, "wiki");
      stop_run();
   endtask

   task automatic test_drop();
      do_start("Key", 3, 3);
      wait_first(261, "drop3");
      sb_q = '{8'h81, 8'hB7, 8'h34, 8'hCA};
      drain(0, "drop3");
      stop_run();
   endtask

   task automatic test_backpressure();
      do_start("Key", 3, 0);
      wait_first(258, "bp");
      sb_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
      drain(1, "bp");
      stop_run();
   endtask

   task automatic test_busy_start();
      do_start("Key", 3, 0);
      repeat (50) @(negedge clk);
      key = mk_key("Wiki"); key_len = LEN_W'(4); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_first(207, "busy_start");
      sb_q = '{8'hEB, 8'h9F, 8'h77, 8'h81};
      drain(0, "busy_start");
      stop_run();
   endtask

   task automatic test_key_err();
      int lens [2] = '{0, KEY_MAX + 1};
      foreach (lens[n]) begin
         @(negedge clk);
         key = mk_key("Key"); key_len = LEN_W'(lens[n]); start = 1'b1;
         @(posedge clk);
         @(negedge clk); start = 1'b0;
         tests++;
         if (key_err !== 1'b1 || busy !== 1'b0 || ks_valid !== 1'b0) begin
            fails++; $display("FAIL key_err len%0d: got e%b b%b v%b want 1 0 0", lens[n], key_err, busy, ks_valid);
         end
         @(negedge clk);
         tests++;
         if (key_err !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL key_err pulse len%0d: got e%b b%b want 0 0", lens[n], key_err, busy);
         end
      end
   endtask

   task automatic test_rst_mid();
      do_start("Key", 3, 0);
      repeat (100) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL rst_mid busy before: got %b want 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || ks_valid !== 1'b0 || key_err !== 1'b0 || ks_data !== 8'h00) begin
         fails++; $display("FAIL rst_mid: got b%b v%b e%b d%h want 0 0 0 00", busy, ks_valid, key_err, ks_data);
      end
      @(negedge clk); rst = 1'b0;
      do_start("Key", 3, 0);
      wait_first(258, "after_rst");
      sb_q = '{8'hEB, 8'h9F, 8'h77};
      drain(0, "after_rst");
   endtask

   task automatic test_stop();
      stop_run();
      tests++;
      if (ks_valid !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL stop: got v%b b%b want 0 0", ks_valid, busy);
      end
      do_start("Key", 3, 0);
      wait_first(258, "after_stop");
      sb_q = '{8'hEB, 8'h9F, 8'h77};
      drain(0, "after_stop");
      stop_run();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_drop();
      test_backpressure();
      test_busy_start();
      test_key_err();
      test_rst_mid();
      test_stop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rc4_stream.md
Name: rc4_stream

Overview:
Parametrised RC4 keystream generator, successor to the fixed 32-bit-key rc4 core.
- Key length is run-time programmable up to KEY_MAX bytes.
- Supports RC4-drop[n] (discard the first n keystream bytes).
- Delivers keystream on a valid/ready byte stream with full backpressure.
- Sits between key-load logic and the XOR datapath of the cipher unit. The S-box is held in internal flops so that one KSA or PRGA step completes per cycle.

Parameters:
KEY_MAX, 16, maximum key length in bytes (1..256)
LEN_W, 5, width of key_len; must hold the value KEY_MAX
DROP_W, 10, width of drop_n

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run INIT+KSA with current key/key_len/drop_n; sampled only in IDLE
stop  in  1  return to IDLE from any non-IDLE state on the next edge
key  in  8*KEY_MAX  key bytes; byte k = key[8k+7:8k]; byte 0 used first
key_len  in  LEN_W  key length in bytes, valid range 1..KEY_MAX
drop_n  in  DROP_W  number of initial keystream bytes to discard
ks_data  out  8  keystream byte
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accepts ks_data when ks_valid&&ks_ready
busy  out  1  high in any state other than IDLE
key_err  out  1  one-cycle pulse: start with key_len==0 or key_len>KEY_MAX

Behaviour:
- Reset (async, asserted): state=IDLE, i=j=0, S[x]=x, ks_data=0, ks_valid=0, busy=0, key_err=0, drop counter=0.
- States: IDLE, INIT, KSA, DROP, GEN.
- Start timing: start accepted at edge E0. key, key_len and drop_n are latched at E0 into internal registers; input changes after E0 have no effect on the run.
- IDLE:
  - start with valid key_len -> INIT.
  - start with invalid key_len -> key_err=1 for one cycle; stay in IDLE.
  - start while busy is ignored.
- INIT: one cycle. All S[x]<=x, i<=0, j<=0 -> KSA.
- KSA: 256 cycles, one iteration per cycle.
  - j' = j + S[i] + K[i mod key_len], 8-bit wrap.
  - Swap S[i] and S[j'] (no-op when i==j'); i <= i+1.
  - After the i==255 iteration: i<=0, j<=0 -> DROP if drop_n!=0, else GEN.
- PRGA step (one per cycle):
  - i' = i+1; j' = j + S[i']; swap S[i'] and S[j'].
  - Output byte = S_new[(S[i'] + S[j']) mod 256], where S_new is the post-swap array. This must be correct when the index equals i' or j'.
- DROP: performs exactly drop_n PRGA steps with no output, then -> GEN.
- GEN:
  - A PRGA step occurs when !ks_valid or (ks_valid && ks_ready); its byte is loaded into ks_data and ks_valid=1.
  - If ks_valid && !ks_ready: ks_data, i, j and S are held.
  - Sustained throughput with ks_ready=1 is one byte per cycle.
  - GEN runs indefinitely until stop or rst.
- Latency: first ks_valid=1 is visible after edge E0+258+drop_n.
- stop:
  - Any non-IDLE state -> IDLE on the next edge; ks_valid<=0; the pending byte is discarded.
  - S, i and j are not preserved. The next start re-runs INIT.
  - stop and start together in IDLE: start wins.
- Reset mid-operation returns all state to reset values immediately; no output byte is produced.
- All index and j arithmetic is modulo 256. The key index is i mod key_len, computed without a divider, e.g. a wrapping key-byte counter reset at INIT.

Test Plan:
- key="Key" (4B 65 79), key_len=3, drop_n=0, ks_ready=1 -> first 10 bytes EB 9F 77 81 B7 34 CA 72 A7 19; first ks_valid after E0+258.
- key="Secret" (53 65 63 72 65 74), key_len=6 -> 04 D4 6B 05 3C A8 7B 59; key="Wiki" (57 69 6B 69), key_len=4 -> 60 44 DB 6D 41 B7.
- key="Key", drop_n=3 -> first delivered byte 81, then B7 34 CA; first ks_valid after E0+261.
- Backpressure: key="Key", ks_ready random 50% -> ks_data stable while stalled; accepted sequence still EB 9F 77 81 B7 ...
- key_len=0, then key_len=KEY_MAX+1 -> key_err pulses once per start, busy stays 0, ks_valid stays 0.
- Mid-run events:
  - rst asserted during KSA at i≈100 -> outputs go to reset values immediately.
  - stop during GEN -> ks_valid=0 and busy=0 next cycle.
  - A new start with "Key" after either event -> EB 9F 77 ... again.
